// File: rtl/frame_ones_pkg.sv
// ---------------------------------------------------------------------------
// frame_ones_pkg
// Shared definitions for the frame ones accumulator:
//   state_t  - controller states (IDLE / ACCUM / HOLD)
//   cntW()   - width of a per-word ones count for a given word width
//   totW()   - width of a frame total that can hold IN_W*FRAME_LEN exactly
// ---------------------------------------------------------------------------
package frame_ones_pkg;

    // IDLE: no words held, ACCUM: partial frame held, HOLD: result presented
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // A word of inW bits can hold 0..inW ones, which needs clog2(inW)+1 bits
    function automatic int cntW(input int inW);
        return $clog2(inW) + 1;
    endfunction

    // The +1 makes the width hold the maximum total itself, not just max-1
    function automatic int totW(input int inW, input int frameLen);
        return $clog2(inW * frameLen + 1);
    endfunction

endpackage

// File: rtl/frame_ones_accum_if.sv
// ---------------------------------------------------------------------------
// frame_ones_accum_if
// Handshake bundle between an upstream ones counter, the frame accumulator
// and the downstream result consumer.
//   in_valid/in_ready/in_count/in_last   - per-word input stream
//   out_valid/out_ready                  - frame result handshake
//   out_total/out_words/out_err          - frame result fields
//   out_over                             - total above threshold, only when
//                                          FRAME_ONES_THRESH_EN is defined
// modport master: the environment (drives inputs, consumes results)
// modport slave : the accumulator
// ---------------------------------------------------------------------------
interface frame_ones_accum_if
    import frame_ones_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int FRAME_LEN = 8
);

    localparam int CNT_W = cntW(IN_W);
    localparam int TOT_W = totW(IN_W, FRAME_LEN);

    logic             in_valid;
    logic             in_ready;
    logic [CNT_W-1:0] in_count;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [TOT_W-1:0] out_total;
    logic [7:0]       out_words;
    logic             out_err;
`ifdef FRAME_ONES_THRESH_EN
    logic             out_over;
`endif

    modport master (
        output in_valid,
        output in_count,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_total,
        input  out_words,
`ifdef FRAME_ONES_THRESH_EN
        input  out_over,
`endif
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_count,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_total,
        output out_words,
`ifdef FRAME_ONES_THRESH_EN
        output out_over,
`endif
        output out_err
    );

endinterface

// File: rtl/frame_ones_accum.sv
// ---------------------------------------------------------------------------
// frame_ones_accum
// Sums per-word ones counts into a frame total. A frame closes after
// FRAME_LEN accepted words or on an accepted word flagged in_last. The
// result is then held until the consumer takes it; no new words are
// accepted while a result is held.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - frame_ones_accum_if.slave (input stream + result handshake)
// Parameters:
//   IN_W      - data word width whose ones are counted upstream
//   FRAME_LEN - maximum words per frame (1..255)
//   THRESH    - out_over threshold, only when FRAME_ONES_THRESH_EN is defined
// ---------------------------------------------------------------------------
module frame_ones_accum
    import frame_ones_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int FRAME_LEN = 8
`ifdef FRAME_ONES_THRESH_EN
    ,
    parameter int THRESH    = IN_W * FRAME_LEN / 2
`endif
) (
    input logic               clk,
    input logic               rst_n,
    frame_ones_accum_if.slave bus
);

    localparam int              CNT_W       = cntW(IN_W);
    localparam int              TOT_W       = totW(IN_W, FRAME_LEN);
    localparam logic [CNT_W-1:0] IN_W_C     = CNT_W'(IN_W);
    localparam logic [7:0]       FRAME_LEN_C = 8'(FRAME_LEN);

    state_t           r_state;
    logic [TOT_W-1:0] r_sum;
    logic [7:0]       r_words;
    logic             r_err;

    logic             w_accept;
    logic             w_badCount;
    logic [CNT_W-1:0] w_clamped;
    logic [TOT_W-1:0] w_nextSum;
    logic [7:0]       w_nextWords;
    logic             w_close;

    // Handshake side: accept anywhere except while a result is held.
    assign bus.in_ready  = (r_state != HOLD);
    assign bus.out_valid = (r_state == HOLD);
    assign w_accept      = bus.in_valid && bus.in_ready;

    // Result fields come straight from the accumulators; they are cleared on
    // consume and on reset, and cannot change in HOLD because nothing is
    // accepted there.
    assign bus.out_total = r_sum;
    assign bus.out_words = r_words;
    assign bus.out_err   = r_err;

    // Saturating contribution of the incoming word: an out-of-range count is
    // clamped to IN_W so the frame total can never exceed IN_W*FRAME_LEN,
    // and the bad count is remembered in the error flag instead.
    always_comb begin
        w_badCount  = 1'b0;
        w_clamped   = bus.in_count;
        if (bus.in_count > IN_W_C) begin
            w_badCount = 1'b1;
            w_clamped  = IN_W_C;
        end
        w_nextSum   = r_sum + TOT_W'(w_clamped);
        w_nextWords = r_words + 8'd1;
        w_close     = w_accept && ((w_nextWords == FRAME_LEN_C) || bus.in_last);
    end

    // Frame controller and accumulators. An accept from IDLE or ACCUM folds
    // the word in and either stays in ACCUM or closes the frame into HOLD;
    // consuming the result in HOLD clears everything back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sum   <= '0;
            r_words <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_sum   <= w_nextSum;
                        r_words <= w_nextWords;
                        r_err   <= r_err | w_badCount;
                        r_state <= w_close ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_sum   <= '0;
                        r_words <= '0;
                        r_err   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_ONES_THRESH_EN
    logic r_over;

    // Threshold flag is computed from the closing sum so it is registered in
    // the same edge as the result and is valid together with out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_over <= 1'b0;
        end else if (w_close) begin
            r_over <= (32'(w_nextSum) > 32'(THRESH));
        end else if ((r_state == HOLD) && bus.out_ready) begin
            r_over <= 1'b0;
        end
    end

    assign bus.out_over = r_over;
`endif

endmodule

// File: tb/tb_frame_ones_accum.sv
// ---------------------------------------------------------------------------
// tb_frame_ones_accum
// Self-checking bench for frame_ones_accum with IN_W=16, FRAME_LEN=4.
// Table of whole-frame vectors plus hand sequences for hold stability,
// in_last without valid, and asynchronous reset mid-frame and in HOLD.
// Define FRAME_ONES_THRESH_EN to also check out_over with THRESH=32.
// ---------------------------------------------------------------------------
module tb_frame_ones_accum;

    localparam int IN_W      = 16;
    localparam int FRAME_LEN = 4;

    logic clk = 1'b0;
    logic rst_n;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        string          name;
        int             nWords;
        logic           useLast;
        logic [3:0][4:0] counts;
        int             expTotal;
        int             expWords;
        logic           expErr;
        logic           expOver;
    } vecT;

    vecT vecs[8];

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    frame_ones_accum_if #(.IN_W(IN_W), .FRAME_LEN(FRAME_LEN)) busIf ();

    frame_ones_accum #(
        .IN_W(IN_W),
        .FRAME_LEN(FRAME_LEN)
`ifdef FRAME_ONES_THRESH_EN
        ,
        .THRESH(32)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (busIf)
    );

    function automatic vecT mkVec(input string name, input int n, input logic useLast,
                                  input int c0, input int c1, input int c2, input int c3,
                                  input int tot, input int words, input logic err,
                                  input logic over);
        vecT v;
        v.name      = name;
        v.nWords    = n;
        v.useLast   = useLast;
        v.counts[0] = 5'(c0);
        v.counts[1] = 5'(c1);
        v.counts[2] = 5'(c2);
        v.counts[3] = 5'(c3);
        v.expTotal  = tot;
        v.expWords  = words;
        v.expErr    = err;
        v.expOver   = over;
        return v;
    endfunction

    // One comparison: counts it, and reports a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present one word for exactly one rising edge; called 1 unit after an edge
    task automatic sendWord(input int count, input logic last);
        busIf.in_valid = 1'b1;
        busIf.in_count = 5'(count);
        busIf.in_last  = last;
        @(posedge clk);
        #1;
        busIf.in_valid = 1'b0;
        busIf.in_last  = 1'b0;
        busIf.in_count = '0;
    endtask

    // Take the held result and confirm the block is back to accepting
    task automatic consume(input string name);
        busIf.out_ready = 1'b1;
        @(posedge clk);
        #1;
        busIf.out_ready = 1'b0;
        checkOutput({name, " out_valid after take"}, 32'(busIf.out_valid), 32'd0);
        checkOutput({name, " in_ready after take"}, 32'(busIf.in_ready), 32'd1);
    endtask

    task automatic checkResult(input vecT v);
        checkOutput({v.name, " out_valid"}, 32'(busIf.out_valid), 32'd1);
        checkOutput({v.name, " out_total"}, 32'(busIf.out_total), 32'(v.expTotal));
        checkOutput({v.name, " out_words"}, 32'(busIf.out_words), 32'(v.expWords));
        checkOutput({v.name, " out_err"}, 32'(busIf.out_err), 32'(v.expErr));
        checkOutput({v.name, " in_ready in hold"}, 32'(busIf.in_ready), 32'd0);
`ifdef FRAME_ONES_THRESH_EN
        checkOutput({v.name, " out_over"}, 32'(busIf.out_over), 32'(v.expOver));
`endif
    endtask

    // Feed a whole frame, check the held result, then consume it
    task automatic applyStimulus(input vecT v);
        for (int w = 0; w < v.nWords; w++) begin
            sendWord(int'(v.counts[w]), v.useLast && (w == v.nWords - 1));
        end
        checkResult(v);
        consume(v.name);
    endtask

    initial begin
        vecs[0] = mkVec("full4",      4, 1'b0,  3, 16, 0, 5, 24, 4, 1'b0, 1'b0);
        vecs[1] = mkVec("early2",     2, 1'b1,  7,  2, 0, 0,  9, 2, 1'b0, 1'b0);
        vecs[2] = mkVec("clamp20",    4, 1'b0, 20,  1, 1, 1, 19, 4, 1'b1, 1'b0);
        vecs[3] = mkVec("errCleared", 4, 1'b0,  1,  1, 1, 1,  4, 4, 1'b0, 1'b0);
        vecs[4] = mkVec("over33",     4, 1'b0, 16, 16, 1, 0, 33, 4, 1'b0, 1'b1);
        vecs[5] = mkVec("atThresh32", 4, 1'b0, 16, 16, 0, 0, 32, 4, 1'b0, 1'b0);
        vecs[6] = mkVec("single31",   1, 1'b1, 31,  0, 0, 0, 16, 1, 1'b1, 1'b0);
        vecs[7] = mkVec("zeros3",     3, 1'b1,  0,  0, 0, 0,  0, 3, 1'b0, 1'b0);

        busIf.in_valid  = 1'b0;
        busIf.in_count  = '0;
        busIf.in_last   = 1'b0;
        busIf.out_ready = 1'b0;
        rst_n           = 1'b0;

        // Reset state
        #12;
        checkOutput("reset in_ready", 32'(busIf.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("reset out_total", 32'(busIf.out_total), 32'd0);
        checkOutput("reset out_words", 32'(busIf.out_words), 32'd0);
        checkOutput("reset out_err", 32'(busIf.out_err), 32'd0);
`ifdef FRAME_ONES_THRESH_EN
        checkOutput("reset out_over", 32'(busIf.out_over), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        // Held result stays put while not taken; in_valid pulses are refused
        sendWord(5, 1'b0);
        sendWord(5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            busIf.in_valid = 1'b1;
            busIf.in_count = 5'd9;
            busIf.in_last  = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("hold out_valid", 32'(busIf.out_valid), 32'd1);
            checkOutput("hold out_total", 32'(busIf.out_total), 32'd10);
            checkOutput("hold out_words", 32'(busIf.out_words), 32'd2);
            checkOutput("hold in_ready", 32'(busIf.in_ready), 32'd0);
        end
        busIf.in_valid = 1'b0;
        busIf.in_last  = 1'b0;
        busIf.in_count = '0;
        consume("hold");
        applyStimulus(mkVec("afterHold", 4, 1'b0, 1, 1, 1, 1, 4, 4, 1'b0, 1'b0));

        // in_last without in_valid must not close or start a frame
        busIf.in_last = 1'b1;
        @(posedge clk);
        #1;
        busIf.in_last = 1'b0;
        checkOutput("lastNoValid out_valid", 32'(busIf.out_valid), 32'd0);
        applyStimulus(mkVec("afterLastNoValid", 4, 1'b0, 2, 2, 2, 2, 8, 4, 1'b0, 1'b0));

        // Asynchronous reset mid-frame, away from any clock edge
        sendWord(9, 1'b0);
        sendWord(9, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset in_ready", 32'(busIf.in_ready), 32'd1);
        checkOutput("midReset out_total", 32'(busIf.out_total), 32'd0);
        checkOutput("midReset out_words", 32'(busIf.out_words), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("midReset quiet out_valid", 32'(busIf.out_valid), 32'd0);
        end
        applyStimulus(mkVec("afterMidReset", 4, 1'b0, 1, 1, 1, 1, 4, 4, 1'b0, 1'b0));

        // Asynchronous reset while a result is held discards it
        sendWord(31, 1'b1);
        checkOutput("holdReset pre out_valid", 32'(busIf.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("holdReset out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("holdReset out_err", 32'(busIf.out_err), 32'd0);
        checkOutput("holdReset out_total", 32'(busIf.out_total), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("holdReset quiet out_valid", 32'(busIf.out_valid), 32'd0);
        applyStimulus(mkVec("afterHoldReset", 4, 1'b0, 1, 1, 1, 1, 4, 4, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/frame_ones_accum.md
FRAME_ONES_ACCUM -- requirements
Module: frame_ones_accum

Interface
REQ-001 Parameter IN_W, default 16: width of the data word whose ones are counted upstream.
REQ-002 Parameter FRAME_LEN, default 8: maximum number of words per frame; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  upstream per-word count is valid.
REQ-006 Port in_ready  output  1  block accepts a word this cycle.
REQ-007 Port in_count  input  $clog2(IN_W)+1  ones count of one word; legal range 0..IN_W.
REQ-008 Port in_last  input  1  accepted word closes the frame early.
REQ-009 Port out_valid  output  1  frame result is available.
REQ-010 Port out_ready  input  1  downstream takes the result.
REQ-011 Port out_total  output  TOT_W = $clog2(IN_W*FRAME_LEN+1)  sum of ones in the frame.
REQ-012 Port out_words  output  8  number of words in the frame, 1..FRAME_LEN.
REQ-013 Port out_err  output  1  at least one in_count > IN_W occurred in the frame.

Function
REQ-014 States: IDLE (no words held), ACCUM (1..FRAME_LEN-1 words held), HOLD (result presented).
REQ-015 A word is accepted when in_valid && in_ready.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; there is no bypass from HOLD.
REQ-017 On accept: sum += min(in_count, IN_W); words += 1; err |= (in_count > IN_W).
REQ-018 A frame closes on the accept that makes words == FRAME_LEN or that carries in_last=1, whichever comes first.
REQ-019 On close, the next cycle SHALL be HOLD with out_valid=1, out_total = final sum, out_words = final count and out_err = final flag; latency is 1 cycle.
REQ-020 Otherwise an accept in IDLE goes to ACCUM, an accept in ACCUM stays in ACCUM, and no accept leaves the state unchanged.
REQ-021 out_total, out_words and out_err SHALL remain stable while out_valid && !out_ready.
REQ-022 On out_valid && out_ready: clear sum, words and err; go to IDLE; in_ready=1 on the following cycle.
REQ-023 FRAME_LEN=1: every accept closes the frame.
REQ-024 Sum never overflows; TOT_W holds IN_W*FRAME_LEN exactly.
REQ-025 in_last is ignored unless the word is accepted.
REQ-026 out_valid is 0 outside HOLD.

Reset
REQ-027 Assertion of rst_n SHALL immediately force IDLE, in_ready=1, out_valid=0, out_total=0, out_words=0, out_err=0, regardless of clk.
REQ-028 Reset mid-frame or in HOLD SHALL discard the partial or unconsumed result; no output follows deassertion until a new frame closes.

Configuration
REQ-029 Macro FRAME_ONES_THRESH_EN compiles in parameter THRESH (default IN_W*FRAME_LEN/2) and output out_over (1 bit); out_over = (out_total > THRESH), is valid with out_valid, and is 0 at reset.
REQ-030 Without FRAME_ONES_THRESH_EN, neither THRESH nor out_over exists, and all other behaviour is identical.

Structure
REQ-031 A shared package frame_ones_pkg SHALL hold the state enum (IDLE/ACCUM/HOLD) and the TOT_W width function.
REQ-032 No sub-module; the saturating add and the FSM are in one module.

Verification (IN_W=16, FRAME_LEN=4)
REQ-033 Four accepts with counts 3,16,0,5 and in_last=0 -> one cycle later out_valid=1, out_total=24, out_words=4, out_err=0.
REQ-034 Counts 7 then 2 with in_last=1 on the second word -> out_total=9, out_words=2.
REQ-035 Result held with out_ready=0 for 5 cycles -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, in_ready=1 on the next cycle.
REQ-036 in_count=20 in a 4-word frame with the others 1,1,1 -> out_total=19, out_err=1; err cleared for the next frame.
REQ-037 rst_n asserted after 2 accepts -> outputs 0 asynchronously; a new 4-word frame of 1s -> out_total=4 with no residue.
REQ-038 With FRAME_ONES_THRESH_EN and THRESH=32: frame of 16,16,1,0 -> out_over=1; frame of 16,16,0,0 -> out_over=0.
